// File: rtl/ifid_stage.sv
// ifid_stage: instruction-fetch stage and IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address and registers the
// fetched word and its PC for decode. Supports stall, flush (bubble) and
// taken-branch redirect. Optional macro IFID_REDIRECT_COUNT_EN adds a
// saturating count of taken-branch redirects on port redirect_count.
module ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_INC    = 32'd1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] oPC,
    output logic [31:0] oPCnext,
    output logic [31:0] oInstr,
    output logic        oValid
`ifdef IFID_REDIRECT_COUNT_EN
    ,
    output logic [15:0] redirect_count
`endif
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    logic [XLEN-1:0] pc_q,     pc_d;
    logic [XLEN-1:0] opc_q,    opc_d;
    logic [XLEN-1:0] opcn_q,   opcn_d;
    logic [XLEN-1:0] instr_q,  instr_d;
    logic            valid_q,  valid_d;
    logic [XLEN-1:0] pc_inc;

    // Sequential PC; wraps modulo 2^32.
    assign pc_inc = pc_q + PC_INC;

    // Next-state selection: branch_taken > flush > stall > normal fetch.
    always_comb begin
        pc_d    = pc_q;
        opc_d   = opc_q;
        opcn_d  = opcn_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (branch_taken) begin
            pc_d    = branch_target;
            opc_d   = '0;
            opcn_d  = '0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (flush) begin
            // PC holds so the same address is refetched after the bubble.
            opc_d   = '0;
            opcn_d  = '0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = pc_inc;
            opc_d   = pc_q;
            opcn_d  = pc_inc;
            instr_d = imem_data;
            valid_d = 1'b1;
        end
    end

    // PC and IF/ID register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            opc_q   <= '0;
            opcn_q  <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            opcn_q  <= opcn_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign oPC       = opc_q;
    assign oPCnext   = opcn_q;
    assign oInstr    = instr_q;
    assign oValid    = valid_q;

`ifdef IFID_REDIRECT_COUNT_EN
    logic [CNT_W-1:0] rcnt_q, rcnt_d;

    // Saturating count of taken-branch redirects.
    always_comb begin
        rcnt_d = rcnt_q;
        if (branch_taken && (rcnt_q != {CNT_W{1'b1}})) begin
            rcnt_d = rcnt_q + CNT_W'(1);
        end
    end

    // Redirect counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end

    assign redirect_count = rcnt_q;
`endif

endmodule

// File: tb/tb_ifid_stage.sv
// Scoreboard bench for ifid_stage: directed stimulus pushes hand-computed
// expectations; a monitor pops and compares one entry per clock edge.
module tb_ifid_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] oPC;
    logic [31:0] oPCnext;
    logic [31:0] oInstr;
    logic        oValid;
`ifdef IFID_REDIRECT_COUNT_EN
    logic [15:0] redirect_count;
`endif

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic [31:0] opc;
        logic [31:0] opcn;
        logic [31:0] ins;
        logic        val;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_cnt = 16'd0;

    ifid_stage dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .oPC           (oPC),
        .oPCnext       (oPCnext),
        .oInstr        (oInstr),
        .oValid        (oValid)
`ifdef IFID_REDIRECT_COUNT_EN
        ,
        .redirect_count(redirect_count)
`endif
    );

    // Instruction memory: mem[a] = 32'h1000_0000 + a, combinational read.
    assign imem_data = 32'h1000_0000 + imem_addr;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic void chk(input string nm, input string fld,
                                input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endfunction

    // Monitor: one expectation per edge, sampled 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk(e.nm, "imem_addr", imem_addr, e.pc);
                chk(e.nm, "oPC",       oPC,       e.opc);
                chk(e.nm, "oPCnext",   oPCnext,   e.opcn);
                chk(e.nm, "oInstr",    oInstr,    e.ins);
                chk(e.nm, "oValid",    32'(oValid), 32'(e.val));
`ifdef IFID_REDIRECT_COUNT_EN
                chk(e.nm, "redirect_count", 32'(redirect_count), 32'(e.cnt));
`endif
            end
        end
    end

    // Drive one cycle of controls and queue the state expected after the edge.
    task automatic cyc(input string nm, input logic rst, input logic st,
                       input logic fl, input logic br, input logic [31:0] tgt,
                       input logic [31:0] e_pc, input logic [31:0] e_opc,
                       input logic [31:0] e_pcn, input logic [31:0] e_ins,
                       input logic e_val);
        exp_t e;
        @(negedge clock);
        reset         = rst;
        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = tgt;
        if (rst) exp_cnt = 16'd0;
        else if (br && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        e.nm = nm; e.pc = e_pc; e.opc = e_opc; e.opcn = e_pcn;
        e.ins = e_ins; e.val = e_val; e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;

        //    name        rst st fl br target        pc            oPC           oPCnext       oInstr        oValid
        cyc("reset0",    1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0);
        cyc("reset1",    1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0);
        cyc("run0",      0, 0, 0, 0, 32'h0,        32'h1,        32'h0,        32'h1,        32'h1000_0000, 1);
        cyc("run1",      0, 0, 0, 0, 32'h0,        32'h2,        32'h1,        32'h2,        32'h1000_0001, 1);
        cyc("run2",      0, 0, 0, 0, 32'h0,        32'h3,        32'h2,        32'h3,        32'h1000_0002, 1);
        cyc("run3",      0, 0, 0, 0, 32'h0,        32'h4,        32'h3,        32'h4,        32'h1000_0003, 1);
        cyc("run4",      0, 0, 0, 0, 32'h0,        32'h5,        32'h4,        32'h5,        32'h1000_0004, 1);
        cyc("stall0",    0, 1, 0, 0, 32'h0,        32'h5,        32'h4,        32'h5,        32'h1000_0004, 1);
        cyc("stall1",    0, 1, 0, 0, 32'h0,        32'h5,        32'h4,        32'h5,        32'h1000_0004, 1);
        cyc("stall2",    0, 1, 0, 0, 32'h0,        32'h5,        32'h4,        32'h5,        32'h1000_0004, 1);
        cyc("unstall",   0, 0, 0, 0, 32'h0,        32'h6,        32'h5,        32'h6,        32'h1000_0005, 1);
        cyc("br_stall",  0, 1, 0, 1, 32'h40,       32'h40,       32'h0,        32'h0,        32'h0,        0);
        cyc("br_tgt",    0, 0, 0, 0, 32'h0,        32'h41,       32'h40,       32'h41,       32'h1000_0040, 1);
        cyc("br_to7",    0, 0, 1, 1, 32'h7,        32'h7,        32'h0,        32'h0,        32'h0,        0);
        cyc("flush7",    0, 0, 1, 0, 32'h0,        32'h7,        32'h0,        32'h0,        32'h0,        0);
        cyc("refetch7",  0, 0, 0, 0, 32'h0,        32'h8,        32'h7,        32'h8,        32'h1000_0007, 1);
        cyc("flush_st",  0, 1, 1, 0, 32'h0,        32'h8,        32'h0,        32'h0,        32'h0,        0);
        cyc("refetch8",  0, 0, 0, 0, 32'h0,        32'h9,        32'h8,        32'h9,        32'h1000_0008, 1);
        cyc("br_max",    0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       32'h0,        32'h0,        0);
        cyc("wrap0",     0, 0, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFF, 32'h0,       32'h0FFF_FFFF, 1);
        cyc("wrap1",     0, 0, 0, 0, 32'h0,        32'h1,        32'h0,        32'h1,        32'h1000_0000, 1);
        cyc("br_to8",    0, 0, 0, 1, 32'h8,        32'h8,        32'h0,        32'h0,        32'h0,        0);
        cyc("at9",       0, 0, 0, 0, 32'h0,        32'h9,        32'h8,        32'h9,        32'h1000_0008, 1);
        cyc("stall9",    0, 1, 0, 0, 32'h0,        32'h9,        32'h8,        32'h9,        32'h1000_0008, 1);
        cyc("rst_mid",   1, 1, 0, 1, 32'h55,       32'h0,        32'h0,        32'h0,        32'h0,        0);
        cyc("post_rst",  0, 0, 0, 0, 32'h0,        32'h1,        32'h0,        32'h1,        32'h1000_0000, 1);
        cyc("cnt_br1",   0, 0, 0, 1, 32'h20,       32'h20,       32'h0,        32'h0,        32'h0,        0);
        cyc("cnt_br2",   0, 1, 0, 1, 32'h20,       32'h20,       32'h0,        32'h0,        32'h0,        0);
        cyc("cnt_flush", 0, 0, 1, 0, 32'h0,        32'h20,       32'h0,        32'h0,        32'h0,        0);
        cyc("cnt_br3",   0, 0, 1, 1, 32'h20,       32'h20,       32'h0,        32'h0,        32'h0,        0);
        cyc("cnt_rst",   1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0);

        @(negedge clock);
        reset = 1'b0;
        stall = 1'b1;
        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clock);
        if (sb_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
